pcie_lane_deskew: RTL and testbench

PCIE_LANE_DESKEW -- requirements
Module: pcie_lane_deskew

---
 rtl/pcie_lane_deskew.sv | 185 ++++++++++++++++++
 tb/tb_pcie_lane_deskew.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_lane_deskew.sv
// pcie_lane_deskew: multi-lane deskew buffer for decoded PCIe symbols.
// Each lane writes into a small circular buffer. While aligning, a lane skips
// symbols until a COM reaches its head and then holds there. Once every active
// lane holds a COM, all lanes read in lockstep. The occupancy difference between
// lanes absorbs the inter-lane skew.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   enable       block active; low returns to idle
//   reverse_in   lane reversal (buffer lane i <- input lane LinkWidth-1-i)
//   lane_mask    per buffer lane, 1 = participates in alignment
//   elec_idle_in per input lane electrical-idle flag (pre-reversal index)
//   link_in      9 bits per input lane, {K, byte}
//   link_out     9 bits per buffer lane, deskewed, registered
//   out_valid    link_out valid (aligned)
//   aligned      state is aligned
//   skew_err     one-cycle pulse when skew exceeds buffer capacity
//   skew_count   skew in symbols captured at the last alignment
module pcie_lane_deskew #(
  parameter int unsigned LinkWidth   = 16,
  parameter int unsigned DeskewDepth = 8,
  localparam int unsigned PtrW       = $clog2(DeskewDepth),
  localparam int unsigned SW         = PtrW + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   reverse_in,
  input  logic [LinkWidth-1:0]   lane_mask,
  input  logic [LinkWidth-1:0]   elec_idle_in,
  input  logic [9*LinkWidth-1:0] link_in,
  output logic [9*LinkWidth-1:0] link_out,
  output logic                   out_valid,
  output logic                   aligned,
  output logic                   skew_err,
  output logic [SW-1:0]          skew_count
);

  localparam logic [8:0]    Com     = 9'h1BC;
  localparam logic [SW-1:0] OccFull = SW'(DeskewDepth - 1);

  typedef enum logic [1:0] {StIdle, StAligning, StAligned} state_e;
  state_e state_q, state_d;

  logic [8:0]      mem    [LinkWidth][DeskewDepth];
  logic [PtrW-1:0] wptr_q [LinkWidth];
  logic [PtrW-1:0] rptr_q [LinkWidth];
  logic [SW-1:0]   occ_q  [LinkWidth];

  // Previous-cycle configuration, used to detect changes that force a flush.
  logic [LinkWidth-1:0] mask_q, active_q;
  logic                 rev_q;

  logic [8:0]           sym  [LinkWidth];
  logic [8:0]           head [LinkWidth];
  logic [LinkWidth-1:0] active, head_com, at_full, wr_en, rd_en;

  logic          any_active, all_hold, overflow, partial_com, cfg_change;
  logic          flush, read_all, aligning_rule, capture, skew_err_d;
  logic [SW-1:0] occ_max, occ_min;

  always_comb begin
    for (int i = 0; i < LinkWidth; i++) begin
      sym[i]      = reverse_in ? link_in[9*(LinkWidth-1-i) +: 9] : link_in[9*i +: 9];
      active[i]   = lane_mask[i] &
                    ~(reverse_in ? elec_idle_in[LinkWidth-1-i] : elec_idle_in[i]);
      head[i]     = mem[i][rptr_q[i]];
      head_com[i] = (occ_q[i] != '0) && (head[i] == Com);
      at_full[i]  = head_com[i] && (occ_q[i] == OccFull);
    end
  end

  always_comb begin
    any_active  = |active;
    all_hold    = any_active && (&(head_com | ~active));
    overflow    = (|(at_full & active)) && !all_hold;
    partial_com = (|(head_com & active)) && !all_hold;
    cfg_change  = (lane_mask != mask_q) || (reverse_in != rev_q) || (active != active_q);

    occ_max = '0;
    occ_min = SW'(DeskewDepth);
    for (int i = 0; i < LinkWidth; i++) begin
      if (active[i]) begin
        if (occ_q[i] > occ_max) occ_max = occ_q[i];
        if (occ_q[i] < occ_min) occ_min = occ_q[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    flush         = 1'b0;
    read_all      = 1'b0;
    aligning_rule = 1'b0;
    capture       = 1'b0;
    skew_err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && any_active) state_d = StAligning;
      end
      StAligning, StAligned: begin
        if (!enable || !any_active || cfg_change) begin
          flush   = 1'b1;
          state_d = (!enable || !any_active) ? StIdle : StAligning;
        end else if (state_q == StAligning) begin
          // All-hold wins over overflow on the same edge.
          if (all_hold) begin
            state_d  = StAligned;
            read_all = 1'b1;
            capture  = 1'b1;
          end else if (overflow) begin
            flush      = 1'b1;
            skew_err_d = 1'b1;
          end else begin
            aligning_rule = 1'b1;
          end
        end else if (partial_com) begin
          // Lost alignment: fall back with pointers intact; COM lanes start holding now.
          state_d       = StAligning;
          aligning_rule = 1'b1;
        end else begin
          read_all = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LinkWidth; i++) begin
      wr_en[i] = active[i] && (read_all || aligning_rule);
      rd_en[i] = active[i] && (read_all ||
                 (aligning_rule && (occ_q[i] != '0) && !head_com[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      active_q   <= '0;
      rev_q      <= 1'b0;
      out_valid  <= 1'b0;
      skew_err   <= 1'b0;
      skew_count <= '0;
      link_out   <= '0;
      for (int i = 0; i < LinkWidth; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        occ_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      mask_q    <= lane_mask;
      active_q  <= active;
      rev_q     <= reverse_in;
      out_valid <= read_all;
      skew_err  <= skew_err_d;
      if (capture) skew_count <= occ_max - occ_min;
      for (int i = 0; i < LinkWidth; i++) begin
        link_out[9*i +: 9] <= (read_all && active[i]) ? head[i] : 9'h000;
        if (flush) begin
          wptr_q[i] <= '0;
          rptr_q[i] <= '0;
          occ_q[i]  <= '0;
        end else begin
          if (wr_en[i]) wptr_q[i] <= wptr_q[i] + PtrW'(1);
          if (rd_en[i]) rptr_q[i] <= rptr_q[i] + PtrW'(1);
          occ_q[i] <= occ_q[i] + SW'(wr_en[i]) - SW'(rd_en[i]);
        end
      end
    end
  end

  // Buffer storage needs no reset; occupancy gates every use of it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LinkWidth; i++) begin
      if (!reset && !flush && wr_en[i]) mem[i][wptr_q[i]] <= sym[i];
    end
  end

  assign aligned = (state_q == StAligned);

endmodule

// File: tb/tb_pcie_lane_deskew.sv
// Directed testbench for pcie_lane_deskew with LinkWidth=4, DeskewDepth=8.
module tb_pcie_lane_deskew;
  localparam int unsigned LW  = 4;
  localparam int unsigned DD  = 8;
  localparam logic [8:0]  COM = 9'h1BC;

  logic        clk = 1'b0;
  logic        reset, enable, reverse_in;
  logic [3:0]  lane_mask, elec_idle_in;
  logic [35:0] link_in, link_out;
  logic        out_valid, aligned, skew_err;
  logic [3:0]  skew_count;
  logic [8:0]  d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcie_lane_deskew #(.LinkWidth(LW), .DeskewDepth(DD)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .reverse_in   (reverse_in),
    .lane_mask    (lane_mask),
    .elec_idle_in (elec_idle_in),
    .link_in      (link_in),
    .link_out     (link_out),
    .out_valid    (out_valid),
    .aligned      (aligned),
    .skew_err     (skew_err),
    .skew_count   (skew_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] l3, input logic [8:0] l2,
                       input logic [8:0] l1, input logic [8:0] l0);
    link_in = {l3, l2, l1, l0};
  endtask

  // Reset, then idle->aligning and a few non-COM writes on every lane.
  task automatic restart();
    reset        = 1'b1;
    enable       = 1'b1;
    lane_mask    = 4'hF;
    elec_idle_in = 4'h0;
    drive(9'h000, 9'h000, 9'h000, 9'h000);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    reverse_in   = 1'b0;
    lane_mask    = 4'hF;
    elec_idle_in = 4'h0;
    drive(COM, COM, COM, COM);
    tick();
    tick();
    check_eq("rst_aligned", aligned, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_skew_err", skew_err, 1'b0);
    check_eq("rst_skew_count", skew_count, 4'd0);
    check_eq("rst_link_out", link_out, 36'h0);

    // Zero skew: COM on all lanes.
    restart();
    drive(COM, COM, COM, COM);
    tick();
    drive(9'h011, 9'h011, 9'h011, 9'h011);
    check_eq("t1_not_yet", aligned, 1'b0);
    tick();
    check_eq("t1_aligned", aligned, 1'b1);
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_com_out", link_out, {COM, COM, COM, COM});
    check_eq("t1_skew", skew_count, 4'd0);
    drive(9'h022, 9'h022, 9'h022, 9'h022);
    tick();
    check_eq("t1_data", link_out, {9'h011, 9'h011, 9'h011, 9'h011});
    enable = 1'b0;
    tick();
    check_eq("t1_dis_aligned", aligned, 1'b0);
    check_eq("t1_dis_valid", out_valid, 1'b0);
    check_eq("t1_dis_out", link_out, 36'h0);
    enable = 1'b1;

    // Lane 3 lags by 3 symbols.
    restart();
    drive(9'h055, COM, COM, COM);
    tick();
    drive(9'h055, 9'h0A1, 9'h0A1, 9'h0A1);
    tick();
    drive(9'h055, 9'h0A2, 9'h0A2, 9'h0A2);
    tick();
    drive(COM, 9'h0A3, 9'h0A3, 9'h0A3);
    tick();
    check_eq("t2_not_yet", aligned, 1'b0);
    drive(9'h0A1, 9'h0A4, 9'h0A4, 9'h0A4);
    tick();
    check_eq("t2_aligned", aligned, 1'b1);
    check_eq("t2_com_out", link_out, {COM, COM, COM, COM});
    check_eq("t2_skew", skew_count, 4'd3);
    drive(9'h0A2, 9'h0A5, 9'h0A5, 9'h0A5);
    tick();
    check_eq("t2_data1", link_out, {9'h0A1, 9'h0A1, 9'h0A1, 9'h0A1});
    tick();
    check_eq("t2_data2", link_out, {9'h0A2, 9'h0A2, 9'h0A2, 9'h0A2});

    // Skew of 7 overflows the buffer.
    restart();
    drive(9'h055, COM, COM, COM);
    tick();
    for (int k = 1; k <= 6; k++) begin
      d = 9'h0A0 + 9'(k);
      drive(9'h055, d, d, d);
      tick();
    end
    check_eq("t3_no_err_yet", skew_err, 1'b0);
    drive(COM, 9'h0A7, 9'h0A7, 9'h0A7);
    tick();
    check_eq("t3_skew_err", skew_err, 1'b1);
    check_eq("t3_not_aligned", aligned, 1'b0);
    check_eq("t3_count_kept", skew_count, 4'd0);
    drive(9'h0A1, 9'h0A8, 9'h0A8, 9'h0A8);
    tick();
    check_eq("t3_err_pulse", skew_err, 1'b0);

    // Skew of 6 is the maximum tolerated.
    restart();
    drive(9'h055, COM, COM, COM);
    tick();
    for (int k = 1; k <= 5; k++) begin
      d = 9'h0A0 + 9'(k);
      drive(9'h055, d, d, d);
      tick();
    end
    drive(COM, 9'h0A6, 9'h0A6, 9'h0A6);
    tick();
    check_eq("t3b_not_yet", aligned, 1'b0);
    drive(9'h0A1, 9'h0A7, 9'h0A7, 9'h0A7);
    tick();
    check_eq("t3b_aligned", aligned, 1'b1);
    check_eq("t3b_no_err", skew_err, 1'b0);
    check_eq("t3b_skew", skew_count, 4'd6);
    check_eq("t3b_com_out", link_out, {COM, COM, COM, COM});
    tick();
    check_eq("t3b_data", link_out, {9'h0A1, 9'h0A1, 9'h0A1, 9'h0A1});

    // Lane reversal, then masking buffer lane 3.
    reverse_in = 1'b1;
    restart();
    drive(COM, COM, COM, COM);
    tick();
    drive(9'h000, 9'h000, 9'h000, 9'h0A5);
    tick();
    check_eq("t4_aligned", aligned, 1'b1);
    tick();
    check_eq("t4_reversed", link_out, {9'h0A5, 9'h000, 9'h000, 9'h000});
    lane_mask = 4'b0111;
    tick();
    check_eq("t4_mask_flush", aligned, 1'b0);
    drive(COM, COM, COM, COM);
    tick();
    drive(9'h0B3, 9'h0B2, 9'h0B1, 9'h0A5);
    tick();
    check_eq("t4_mask_aligned", aligned, 1'b1);
    check_eq("t4_mask_com", link_out, {9'h000, COM, COM, COM});
    tick();
    check_eq("t4_mask_data", link_out, {9'h000, 9'h0B1, 9'h0B2, 9'h0B3});
    reverse_in = 1'b0;

    // Single-lane COM drops alignment; realign; reset while aligned.
    restart();
    drive(COM, COM, COM, COM);
    tick();
    drive(9'h011, 9'h011, 9'h011, 9'h011);
    tick();
    check_eq("t5_aligned", aligned, 1'b1);
    drive(9'h011, COM, 9'h011, 9'h011);
    tick();
    check_eq("t5_still", aligned, 1'b1);
    drive(9'h022, 9'h022, 9'h022, 9'h022);
    tick();
    check_eq("t5_dropped", aligned, 1'b0);
    check_eq("t5_drop_valid", out_valid, 1'b0);
    check_eq("t5_drop_no_err", skew_err, 1'b0);
    drive(9'h033, 9'h033, 9'h033, 9'h033);
    tick();
    drive(COM, COM, COM, COM);
    tick();
    check_eq("t5_not_yet", aligned, 1'b0);
    drive(9'h044, 9'h044, 9'h044, 9'h044);
    tick();
    check_eq("t5_realigned", aligned, 1'b1);
    check_eq("t5_skew", skew_count, 4'd3);
    check_eq("t5_com_out", link_out, {COM, COM, COM, COM});
    reset = 1'b1;
    tick();
    check_eq("t5_rst_aligned", aligned, 1'b0);
    check_eq("t5_rst_valid", out_valid, 1'b0);
    check_eq("t5_rst_out", link_out, 36'h0);
    check_eq("t5_rst_skew", skew_count, 4'd0);
    check_eq("t5_rst_err", skew_err, 1'b0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
